// File: rtl/etapa_mem.sv
// MEM pipeline stage: runs loads/stores over a req/ack data-memory port and registers MEM/WB.
// Stalls upstream while an access is outstanding; aborts on misalignment or timeout.
module etapa_mem #(
  parameter int unsigned ESPERA_MAX = 16
) (
  input  logic        clk,
  input  logic        reinicio,
  input  logic        ex_valido,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_resultado_alu,
  input  logic [31:0] ex_dato_mem,
  input  logic [4:0]  ex_registro_destino,
  input  logic        ex_lee,
  input  logic        ex_escribe,
  input  logic [1:0]  ex_tamano,
  input  logic        ex_sin_signo,
  output logic        detener,
  output logic        mem_req,
  output logic        mem_escribe,
  output logic [31:0] mem_dir,
  output logic [31:0] mem_dato_escritura,
  output logic [3:0]  mem_mascara,
  input  logic        mem_ack,
  input  logic [31:0] mem_dato_lectura,
  output logic        wb_valido,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_resultado,
  output logic [4:0]  wb_registro_destino,
  output logic        error_alineacion,
  output logic        error_tiempo
);

  typedef enum logic [0:0] {
    LIBRE  = 1'b0,
    ACCESO = 1'b1
  } estado_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] resultado;
    logic [4:0]  rd;
    logic        err;
  } retiro_t;

  localparam int unsigned CW = (ESPERA_MAX > 1) ? $clog2(ESPERA_MAX) : 1;
  localparam logic [CW-1:0] LIMITE = CW'(ESPERA_MAX - 1);

  estado_t       estado_q;
  logic [CW-1:0] contador_q;

  // Operation latched for the access in flight
  logic          op_lee_q;
  logic [31:0]   op_pc_q;
  logic [31:0]   op_dir_q;
  logic [1:0]    op_tamano_q;
  logic          op_sin_signo_q;
  logic [4:0]    op_rd_q;

  // An immediate retirement that collided with a memory completion waits here one cycle
  logic          pend_valido_q;
  retiro_t       pend_q;

  logic          mem_req_q;
  logic          mem_escribe_q;
  logic [31:0]   mem_dir_q;
  logic [31:0]   mem_dato_escritura_q;
  logic [3:0]    mem_mascara_q;
  logic          wb_valido_q;
  logic [31:0]   wb_pc_q;
  logic [31:0]   wb_resultado_q;
  logic [4:0]    wb_registro_destino_q;
  logic          error_alineacion_q;
  logic          error_tiempo_q;

  logic          ack_ok;
  logic          limite;
  logic          mem_fin;
  logic          aceptar;
  logic          ex_es_mem;
  logic          ex_alineado;
  logic          lanzar;
  logic          inmediato;
  logic          ocupado_wb;
  logic [3:0]    ex_mascara;
  logic [31:0]   ex_dato_esc;
  logic [31:0]   lectura_desplazada;
  logic [31:0]   dato_cargado;
  retiro_t       ret_inm;
  retiro_t       ret_mem;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    ex_alineado = 1'b1;
    ex_mascara  = 4'b1111;
    ex_dato_esc = ex_dato_mem;
    case (ex_tamano)
      2'b00: begin
        ex_alineado = 1'b1;
        ex_mascara  = 4'b0001 << ex_resultado_alu[1:0];
        ex_dato_esc = {4{ex_dato_mem[7:0]}};
      end
      2'b01: begin
        ex_alineado = ~ex_resultado_alu[0];
        ex_mascara  = 4'b0011 << ex_resultado_alu[1:0];
        ex_dato_esc = {2{ex_dato_mem[15:0]}};
      end
      default: begin
        ex_alineado = (ex_resultado_alu[1:0] == 2'b00);
        ex_mascara  = 4'b1111;
        ex_dato_esc = ex_dato_mem;
      end
    endcase
    // Reads fetch the whole word; lane selection happens on the returned data
    if (ex_lee) begin
      ex_mascara = 4'b1111;
    end
  end

  assign ex_es_mem  = ex_lee | ex_escribe;
  assign ack_ok     = (estado_q == ACCESO) & mem_ack;
  assign limite     = (estado_q == ACCESO) & ~mem_ack & (contador_q == LIMITE);
  assign mem_fin    = ack_ok | limite;
  assign aceptar    = ex_valido & ((estado_q == LIBRE) | ack_ok);
  assign lanzar     = aceptar & ex_es_mem & ex_alineado;
  assign inmediato  = aceptar & ~(ex_es_mem & ex_alineado);
  assign ocupado_wb = mem_fin | pend_valido_q;
  assign detener    = (estado_q == ACCESO) & ~mem_ack;

  assign lectura_desplazada = mem_dato_lectura >> {op_dir_q[1:0], 3'b000};

  always_comb begin
    dato_cargado = lectura_desplazada;
    case (op_tamano_q)
      2'b00: dato_cargado = op_sin_signo_q ? {24'd0, lectura_desplazada[7:0]}
                                           : {{24{lectura_desplazada[7]}}, lectura_desplazada[7:0]};
      2'b01: dato_cargado = op_sin_signo_q ? {16'd0, lectura_desplazada[15:0]}
                                           : {{16{lectura_desplazada[15]}}, lectura_desplazada[15:0]};
      default: dato_cargado = lectura_desplazada;
    endcase
  end

  always_comb begin
    ret_inm.pc        = ex_pc;
    ret_inm.resultado = ex_resultado_alu;
    ret_inm.rd        = ex_es_mem ? 5'd0 : ex_registro_destino;
    ret_inm.err       = ex_es_mem;

    ret_mem.pc        = op_pc_q;
    ret_mem.resultado = (ack_ok & op_lee_q) ? dato_cargado : op_dir_q;
    ret_mem.rd        = (ack_ok & op_lee_q) ? op_rd_q : 5'd0;
    ret_mem.err       = 1'b0;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reinicio) begin
      estado_q              <= LIBRE;
      contador_q            <= '0;
      op_lee_q              <= 1'b0;
      op_pc_q               <= '0;
      op_dir_q              <= '0;
      op_tamano_q           <= '0;
      op_sin_signo_q        <= 1'b0;
      op_rd_q               <= '0;
      pend_valido_q         <= 1'b0;
      pend_q                <= '0;
      mem_req_q             <= 1'b0;
      mem_escribe_q         <= 1'b0;
      mem_dir_q             <= '0;
      mem_dato_escritura_q  <= '0;
      mem_mascara_q         <= '0;
      wb_valido_q           <= 1'b0;
      wb_pc_q               <= '0;
      wb_resultado_q        <= '0;
      wb_registro_destino_q <= '0;
      error_alineacion_q    <= 1'b0;
      error_tiempo_q        <= 1'b0;
    end else begin
      wb_valido_q        <= 1'b0;
      error_alineacion_q <= 1'b0;
      error_tiempo_q     <= 1'b0;

      // A memory completion and a pending entry never coexist: pending implies LIBRE
      if (mem_fin) begin
        wb_valido_q           <= 1'b1;
        wb_pc_q               <= ret_mem.pc;
        wb_resultado_q        <= ret_mem.resultado;
        wb_registro_destino_q <= ret_mem.rd;
        error_tiempo_q        <= limite;
      end else if (pend_valido_q) begin
        wb_valido_q           <= 1'b1;
        wb_pc_q               <= pend_q.pc;
        wb_resultado_q        <= pend_q.resultado;
        wb_registro_destino_q <= pend_q.rd;
        error_alineacion_q    <= pend_q.err;
      end else if (inmediato) begin
        wb_valido_q           <= 1'b1;
        wb_pc_q               <= ret_inm.pc;
        wb_resultado_q        <= ret_inm.resultado;
        wb_registro_destino_q <= ret_inm.rd;
        error_alineacion_q    <= ret_inm.err;
      end

      pend_valido_q <= inmediato & ocupado_wb;
      if (inmediato & ocupado_wb) begin
        pend_q <= ret_inm;
      end

      if (lanzar) begin
        estado_q             <= ACCESO;
        contador_q           <= '0;
        op_lee_q             <= ex_lee;
        op_pc_q              <= ex_pc;
        op_dir_q             <= ex_resultado_alu;
        op_tamano_q          <= ex_tamano;
        op_sin_signo_q       <= ex_sin_signo;
        op_rd_q              <= ex_registro_destino;
        mem_req_q            <= 1'b1;
        mem_escribe_q        <= ~ex_lee;
        mem_dir_q            <= {ex_resultado_alu[31:2], 2'b00};
        mem_dato_escritura_q <= ex_dato_esc;
        mem_mascara_q        <= ex_mascara;
      end else if (mem_fin) begin
        estado_q  <= LIBRE;
        mem_req_q <= 1'b0;
      end else if (estado_q == ACCESO) begin
        contador_q <= contador_q + 1'b1;
      end
    end
  end

  assign mem_req             = mem_req_q;
  assign mem_escribe         = mem_escribe_q;
  assign mem_dir             = mem_dir_q;
  assign mem_dato_escritura  = mem_dato_escritura_q;
  assign mem_mascara         = mem_mascara_q;
  assign wb_valido           = wb_valido_q;
  assign wb_pc               = wb_pc_q;
  assign wb_resultado        = wb_resultado_q;
  assign wb_registro_destino = wb_registro_destino_q;
  assign error_alineacion    = error_alineacion_q;
  assign error_tiempo        = error_tiempo_q;

endmodule

// File: tb/tb_etapa_mem.sv
// Directed bench for etapa_mem with ESPERA_MAX=4: ALU retire, loads/stores, misalignment,
// timeout, back-to-back ops and reset during an access.
module tb_etapa_mem;

  logic        clk = 1'b0;
  logic        reinicio;
  logic        ex_valido;
  logic [31:0] ex_pc;
  logic [31:0] ex_resultado_alu;
  logic [31:0] ex_dato_mem;
  logic [4:0]  ex_registro_destino;
  logic        ex_lee;
  logic        ex_escribe;
  logic [1:0]  ex_tamano;
  logic        ex_sin_signo;
  logic        detener;
  logic        mem_req;
  logic        mem_escribe;
  logic [31:0] mem_dir;
  logic [31:0] mem_dato_escritura;
  logic [3:0]  mem_mascara;
  logic        mem_ack;
  logic [31:0] mem_dato_lectura;
  logic        wb_valido;
  logic [31:0] wb_pc;
  logic [31:0] wb_resultado;
  logic [4:0]  wb_registro_destino;
  logic        error_alineacion;
  logic        error_tiempo;

  int errors = 0;
  int checks = 0;

  etapa_mem #(.ESPERA_MAX(4)) dut (
    .clk                 (clk),
    .reinicio            (reinicio),
    .ex_valido           (ex_valido),
    .ex_pc               (ex_pc),
    .ex_resultado_alu    (ex_resultado_alu),
    .ex_dato_mem         (ex_dato_mem),
    .ex_registro_destino (ex_registro_destino),
    .ex_lee              (ex_lee),
    .ex_escribe          (ex_escribe),
    .ex_tamano           (ex_tamano),
    .ex_sin_signo        (ex_sin_signo),
    .detener             (detener),
    .mem_req             (mem_req),
    .mem_escribe         (mem_escribe),
    .mem_dir             (mem_dir),
    .mem_dato_escritura  (mem_dato_escritura),
    .mem_mascara         (mem_mascara),
    .mem_ack             (mem_ack),
    .mem_dato_lectura    (mem_dato_lectura),
    .wb_valido           (wb_valido),
    .wb_pc               (wb_pc),
    .wb_resultado        (wb_resultado),
    .wb_registro_destino (wb_registro_destino),
    .error_alineacion    (error_alineacion),
    .error_tiempo        (error_tiempo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sin_op();
    ex_valido           = 1'b0;
    ex_pc               = '0;
    ex_resultado_alu    = '0;
    ex_dato_mem         = '0;
    ex_registro_destino = '0;
    ex_lee              = 1'b0;
    ex_escribe          = 1'b0;
    ex_tamano           = 2'b00;
    ex_sin_signo        = 1'b0;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dato,
                        input logic [4:0] rd, input logic lee, input logic esc,
                        input logic [1:0] tam, input logic ss);
    ex_valido           = 1'b1;
    ex_pc               = pc;
    ex_resultado_alu    = alu;
    ex_dato_mem         = dato;
    ex_registro_destino = rd;
    ex_lee              = lee;
    ex_escribe          = esc;
    ex_tamano           = tam;
    ex_sin_signo        = ss;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reinicio         = 1'b1;
    mem_ack          = 1'b0;
    mem_dato_lectura = '0;
    sin_op();
    tick();
    tick();
    check("rst_wb_valido", wb_valido, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_detener", detener, 0);
    check("rst_wb_resultado", wb_resultado, 0);
    reinicio = 1'b0;

    // 1: ALU op retires with latency 1, no stall
    set_ex(32'h10, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 2'b10, 1'b0);
    #1;
    check("alu_detener", detener, 0);
    tick();
    check("alu_wb_valido", wb_valido, 1);
    check("alu_wb_resultado", wb_resultado, 32'h1234);
    check("alu_wb_rd", wb_registro_destino, 5);
    check("alu_wb_pc", wb_pc, 32'h10);
    check("alu_detener_after", detener, 0);
    sin_op();
    tick();
    check("idle_wb_valido", wb_valido, 0);
    check("idle_wb_hold", wb_resultado, 32'h1234);

    // 2: signed byte load at 0x103, three wait cycles
    set_ex(32'h20, 32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 2'b00, 1'b0);
    tick();
    sin_op();
    check("lb_mem_req", mem_req, 1);
    check("lb_mem_escribe", mem_escribe, 0);
    check("lb_mem_dir", mem_dir, 32'h100);
    check("lb_mascara", mem_mascara, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      check("lb_detener_wait", detener, 1);
      tick();
    end
    mem_ack          = 1'b1;
    mem_dato_lectura = 32'h80FF_FF00;
    #1;
    check("lb_detener_ack", detener, 0);
    tick();
    mem_ack = 1'b0;
    check("lb_wb_valido", wb_valido, 1);
    check("lb_wb_resultado", wb_resultado, 32'hFFFF_FF80);
    check("lb_wb_rd", wb_registro_destino, 7);
    check("lb_err_tiempo", error_tiempo, 0);
    check("lb_mem_req_drop", mem_req, 0);

    // 3: store half at 0x22, immediate ack, next load accepted at the same edge
    set_ex(32'h30, 32'h22, 32'h0000_ABCD, 5'd9, 1'b0, 1'b1, 2'b01, 1'b0);
    tick();
    check("sh_mem_escribe", mem_escribe, 1);
    check("sh_mascara", mem_mascara, 4'b1100);
    check("sh_dato", mem_dato_escritura, 32'hABCD_ABCD);
    check("sh_mem_dir", mem_dir, 32'h20);
    set_ex(32'h34, 32'h44, 32'h0, 5'd3, 1'b1, 1'b0, 2'b10, 1'b1);
    mem_ack = 1'b1;
    #1;
    check("sh_detener_ack", detener, 0);
    tick();
    check("sh_wb_valido", wb_valido, 1);
    check("sh_wb_rd", wb_registro_destino, 0);
    check("sh_wb_pc", wb_pc, 32'h30);
    check("b2b_mem_req", mem_req, 1);
    check("b2b_mem_escribe", mem_escribe, 0);
    check("b2b_mem_dir", mem_dir, 32'h44);
    sin_op();
    mem_dato_lectura = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    check("lw_wb_resultado", wb_resultado, 32'hDEAD_BEEF);
    check("lw_wb_rd", wb_registro_destino, 3);
    check("lw_mem_req_drop", mem_req, 0);

    // Unsigned half load with an ALU op waiting behind it; both retire in order
    set_ex(32'h40, 32'h52, 32'h0, 5'd10, 1'b1, 1'b0, 2'b01, 1'b1);
    tick();
    set_ex(32'h44, 32'h77, 32'h0, 5'd4, 1'b0, 1'b0, 2'b10, 1'b0);
    mem_ack          = 1'b1;
    mem_dato_lectura = 32'h8001_1234;
    tick();
    mem_ack = 1'b0;
    sin_op();
    check("lhu_wb_pc", wb_pc, 32'h40);
    check("lhu_wb_resultado", wb_resultado, 32'h0000_8001);
    check("lhu_wb_rd", wb_registro_destino, 10);
    tick();
    check("after_lhu_wb_valido", wb_valido, 1);
    check("after_lhu_wb_pc", wb_pc, 32'h44);
    check("after_lhu_wb_resultado", wb_resultado, 32'h77);
    check("after_lhu_wb_rd", wb_registro_destino, 4);

    // Store byte at 0x13
    set_ex(32'h48, 32'h13, 32'h0000_005A, 5'd2, 1'b0, 1'b1, 2'b00, 1'b0);
    tick();
    sin_op();
    check("sb_mascara", mem_mascara, 4'b1000);
    check("sb_dato", mem_dato_escritura, 32'h5A5A_5A5A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_wb_rd", wb_registro_destino, 0);

    // 4: misaligned word load
    set_ex(32'h50, 32'h41, 32'h0, 5'd6, 1'b1, 1'b0, 2'b10, 1'b0);
    #1;
    check("mis_detener", detener, 0);
    tick();
    sin_op();
    check("mis_mem_req", mem_req, 0);
    check("mis_err_alin", error_alineacion, 1);
    check("mis_wb_valido", wb_valido, 1);
    check("mis_wb_rd", wb_registro_destino, 0);
    tick();
    check("mis_err_pulse", error_alineacion, 0);

    // 5a: timeout, new op held behind the abort
    set_ex(32'h60, 32'h80, 32'h0, 5'd2, 1'b1, 1'b0, 2'b10, 1'b0);
    tick();
    set_ex(32'h64, 32'h99, 32'h0, 5'd8, 1'b0, 1'b0, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("to_mem_req_high", mem_req, 1);
      check("to_detener", detener, 1);
      tick();
    end
    check("to_mem_req_drop", mem_req, 0);
    check("to_err_tiempo", error_tiempo, 1);
    check("to_wb_valido", wb_valido, 1);
    check("to_wb_rd", wb_registro_destino, 0);
    check("to_wb_pc", wb_pc, 32'h60);
    tick();
    sin_op();
    check("to_next_wb_pc", wb_pc, 32'h64);
    check("to_next_wb_resultado", wb_resultado, 32'h99);
    check("to_next_err_tiempo", error_tiempo, 0);

    // 5b: ack arriving in the 4th cycle wins over the timeout
    set_ex(32'h70, 32'h90, 32'h1122_3344, 5'd1, 1'b0, 1'b1, 2'b10, 1'b0);
    tick();
    sin_op();
    check("sw_dato", mem_dato_escritura, 32'h1122_3344);
    check("sw_mascara", mem_mascara, 4'b1111);
    for (int i = 0; i < 3; i++) tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("lim_wb_valido", wb_valido, 1);
    check("lim_err_tiempo", error_tiempo, 0);
    check("lim_mem_req", mem_req, 0);

    // 6: reset during the 2nd wait cycle
    set_ex(32'h80, 32'hA1, 32'h0, 5'd1, 1'b1, 1'b0, 2'b00, 1'b0);
    tick();
    sin_op();
    tick();
    reinicio = 1'b1;
    tick();
    reinicio = 1'b0;
    check("rmid_mem_req", mem_req, 0);
    check("rmid_detener", detener, 0);
    check("rmid_wb_valido", wb_valido, 0);
    check("rmid_mem_dir", mem_dir, 0);
    check("rmid_wb_pc", wb_pc, 0);
    check("rmid_wb_resultado", wb_resultado, 0);
    tick();
    check("rmid_wb_valido_after", wb_valido, 0);
    mem_ack = 1'b1;
    #1;
    check("stray_ack_detener", detener, 0);
    tick();
    mem_ack = 1'b0;
    check("stray_ack_wb_valido", wb_valido, 0);
    check("stray_ack_mem_req", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
